// File: rtl/icache_direct_pkg.sv
// Shared parameters, address-field helpers and FSM state encoding for the
// direct-mapped instruction cache.
package icache_direct_pkg;

    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned INDEX_BITS  = 4;
    localparam int unsigned OFFSET_BITS = 2;
    localparam int unsigned TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS - 2;
    localparam int unsigned LINE_WORDS  = 1 << OFFSET_BITS;
    localparam int unsigned LINE_COUNT  = 1 << INDEX_BITS;

    typedef logic [TAG_BITS-1:0]    ic_tag_t;
    typedef logic [INDEX_BITS-1:0]  ic_index_t;
    typedef logic [OFFSET_BITS-1:0] ic_offset_t;

    localparam ic_offset_t LAST_WORD = ic_offset_t'(LINE_WORDS - 1);

    // Byte address split: tag | index | word offset | byte-in-word
    typedef struct packed {
        ic_tag_t    tag;
        ic_index_t  index;
        ic_offset_t offset;
        logic [1:0] byte_sel;
    } ic_pc_fields_t;

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_FILL = 2'd1,
        IC_RESP = 2'd2
    } ic_state_t;

endpackage

// File: rtl/icache_direct_if.sv
// Fetcher, RoB flush and memory-controller signals of the instruction cache.
// The cache is the slave; the surrounding pipeline/memory side is the master.
interface icache_direct_if;
    import icache_direct_pkg::*;

    logic                  IFIC_en;
    logic [ADDR_WIDTH-1:0] IFIC_pc;
    logic                  ICIF_en;
    logic [31:0]           ICIF_data;
    logic                  RoBIC_flush;
    logic                  ICMC_en;
    logic [ADDR_WIDTH-1:0] ICMC_addr;
    logic                  MCIC_en;
    logic [31:0]           MCIC_data;

    modport master (
        output IFIC_en, IFIC_pc, RoBIC_flush, MCIC_en, MCIC_data,
        input  ICIF_en, ICIF_data, ICMC_en, ICMC_addr
    );

    modport slave (
        input  IFIC_en, IFIC_pc, RoBIC_flush, MCIC_en, MCIC_data,
        output ICIF_en, ICIF_data, ICMC_en, ICMC_addr
    );

endinterface

// File: rtl/icache_direct_line_store.sv
// Valid/tag/data arrays of the direct-mapped cache: combinational lookup,
// per-word data write, tag+valid write, synchronous clear of all valid bits.
module icache_line_store
    import icache_direct_pkg::*;
(
    input  logic       Sys_clk,
    input  logic       clr,
    // lookup port
    input  ic_index_t  rd_index,
    input  ic_offset_t rd_offset,
    input  ic_tag_t    rd_tag,
    output logic       rd_hit,
    output logic [31:0] rd_word,
    // data word write port
    input  logic       word_we,
    input  ic_index_t  wr_index,
    input  ic_offset_t wr_offset,
    input  logic [31:0] wr_data,
    // tag/valid write port
    input  logic       tag_we,
    input  ic_index_t  tag_index,
    input  ic_tag_t    tag_wdata
);

    logic [LINE_COUNT-1:0] valid_q;
    ic_tag_t               tag_q  [LINE_COUNT];
    logic [31:0]           data_q [LINE_COUNT][LINE_WORDS];

    // Combinational lookup
    always_comb begin
        rd_word = data_q[rd_index][rd_offset];
        rd_hit  = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
    end

    // Data words are written one beat at a time during a fill
    always_ff @(posedge Sys_clk) begin
        if (word_we) begin
            data_q[wr_index][wr_offset] <= wr_data;
        end
    end

    // Valid bits clear only on reset; a completed fill stamps tag and valid
    always_ff @(posedge Sys_clk) begin
        if (clr) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[tag_index] <= 1'b1;
            tag_q[tag_index]   <= tag_wdata;
        end
    end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: one fetch at a time, hits answer
// next cycle, misses fill the whole line from the memory controller first.
module icache_direct
    import icache_direct_pkg::*;
(
    input  logic             Sys_clk,
    input  logic             Sys_rst,
    input  logic             Sys_rdy,
    icache_direct_if.slave   bus
);

    ic_state_t     state;
    ic_offset_t    word_cnt;
    ic_tag_t       req_tag;
    ic_index_t     req_index;
    ic_offset_t    req_offset;
    logic          flush_pend;

    ic_pc_fields_t pc_f;
    ic_index_t     rd_index;
    ic_offset_t    rd_offset;
    ic_tag_t       rd_tag;
    logic          rd_hit;
    logic [31:0]   rd_word;
    logic          accept;
    logic          fill_beat;
    logic          fill_last;
    logic [31:0]   resp_word;
    logic          unused_byte_sel;

    assign pc_f            = bus.IFIC_pc;
    assign unused_byte_sel = ^pc_f.byte_sel;

    // Lookup uses the live pc while idle and the latched request otherwise
    always_comb begin
        if (state == IC_IDLE) begin
            rd_tag    = pc_f.tag;
            rd_index  = pc_f.index;
            rd_offset = pc_f.offset;
        end else begin
            rd_tag    = req_tag;
            rd_index  = req_index;
            rd_offset = req_offset;
        end
    end

    // Handshake qualifiers and the word returned at the end of a fill
    always_comb begin
        accept    = bus.IFIC_en && !bus.ICIF_en && !bus.RoBIC_flush;
        fill_beat = Sys_rst && Sys_rdy && (state == IC_FILL)
                    && bus.ICMC_en && bus.MCIC_en;
        fill_last = fill_beat && (word_cnt == LAST_WORD);
        // The requested word may be the one arriving on this very beat
        resp_word = (req_offset == word_cnt) ? bus.MCIC_data : rd_word;
    end

    icache_line_store u_store (
        .Sys_clk   (Sys_clk),
        .clr       (!Sys_rst),
        .rd_index  (rd_index),
        .rd_offset (rd_offset),
        .rd_tag    (rd_tag),
        .rd_hit    (rd_hit),
        .rd_word   (rd_word),
        .word_we   (fill_beat),
        .wr_index  (req_index),
        .wr_offset (word_cnt),
        .wr_data   (bus.MCIC_data),
        .tag_we    (fill_last),
        .tag_index (req_index),
        .tag_wdata (req_tag)
    );

    // Control FSM with registered fetcher and memory-side outputs
    always_ff @(posedge Sys_clk) begin
        if (!Sys_rst) begin
            state         <= IC_IDLE;
            word_cnt      <= '0;
            req_tag       <= '0;
            req_index     <= '0;
            req_offset    <= '0;
            flush_pend    <= 1'b0;
            bus.ICIF_en   <= 1'b0;
            bus.ICIF_data <= '0;
            bus.ICMC_en   <= 1'b0;
            bus.ICMC_addr <= '0;
        end else if (Sys_rdy) begin
            case (state)
                IC_IDLE: begin
                    bus.ICIF_en <= 1'b0;
                    if (accept) begin
                        req_tag    <= pc_f.tag;
                        req_index  <= pc_f.index;
                        req_offset <= pc_f.offset;
                        if (rd_hit) begin
                            bus.ICIF_en   <= 1'b1;
                            bus.ICIF_data <= rd_word;
                        end else begin
                            state         <= IC_FILL;
                            word_cnt      <= '0;
                            flush_pend    <= 1'b0;
                            bus.ICMC_en   <= 1'b1;
                            bus.ICMC_addr <= {pc_f.tag, pc_f.index, ic_offset_t'(0), 2'b00};
                        end
                    end
                end
                IC_FILL: begin
                    bus.ICIF_en <= 1'b0;
                    if (bus.RoBIC_flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (fill_beat) begin
                        if (fill_last) begin
                            bus.ICMC_en <= 1'b0;
                            // A flush seen at any point of the fill drops the response
                            if (flush_pend || bus.RoBIC_flush) begin
                                state <= IC_IDLE;
                            end else begin
                                state         <= IC_RESP;
                                bus.ICIF_en   <= 1'b1;
                                bus.ICIF_data <= resp_word;
                            end
                        end else begin
                            word_cnt      <= word_cnt + 1'b1;
                            bus.ICMC_addr <= bus.ICMC_addr + ADDR_WIDTH'(4);
                        end
                    end
                end
                IC_RESP: begin
                    bus.ICIF_en <= 1'b0;
                    state       <= IC_IDLE;
                end
                default: begin
                    bus.ICIF_en <= 1'b0;
                    state       <= IC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: a line-level cache model predicts hit or
// miss and the returned word; a monitor checks every ICIF_en pulse.
module tb_icache_direct;

    logic Sys_clk;
    logic Sys_rst;
    logic Sys_rdy;

    icache_direct_if bus ();

    icache_direct dut (
        .Sys_clk (Sys_clk),
        .Sys_rst (Sys_rst),
        .Sys_rdy (Sys_rdy),
        .bus     (bus)
    );

    initial begin
        Sys_clk = 1'b0;
        forever #5 Sys_clk = ~Sys_clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q [$];

    // Reference cache state: one tag and valid bit per line
    bit          m_valid [16];
    logic [23:0] m_tag   [16];

    // Backing memory contents as a pure function of the word address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a << 5) + 32'h13) ^ ((a >> 8) * 32'h9E37_79B9);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every response pulse must match the oldest expected word
    always @(negedge Sys_clk) begin
        if (bus.ICIF_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got pulse data %h expected no pulse at %0t",
                         bus.ICIF_data, $time);
            end else begin
                chk("resp_data", bus.ICIF_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // One fetch; the memory side answers the fill with optional gaps, a
    // Sys_rdy stall before word stall_before, and a flush after flush_after words
    task automatic fetch(input logic [31:0] pc, input int flush_after,
                         input int stall_before, input bit rand_gap);
        logic [3:0]  ix;
        logic [23:0] tg;
        logic [31:0] base;
        bit          hit;
        bit          flushed;
        ix      = pc[7:4];
        tg      = pc[31:8];
        base    = {pc[31:4], 4'h0};
        hit     = m_valid[ix] && (m_tag[ix] == tg);
        flushed = 1'b0;
        bus.IFIC_pc = pc;
        bus.IFIC_en = 1'b1;
        if (hit) exp_q.push_back(mem_word({pc[31:2], 2'b00}));
        @(negedge Sys_clk);
        if (hit) begin
            chk("hit_pulse", {31'd0, bus.ICIF_en}, 32'd1);
            chk("hit_no_mem", {31'd0, bus.ICMC_en}, 32'd0);
            // IFIC_en stays high through the pulse cycle: must not re-accept
            @(negedge Sys_clk);
            bus.IFIC_en = 1'b0;
            chk("hit_single", {31'd0, bus.ICIF_en}, 32'd0);
        end else begin
            bus.IFIC_en = 1'b0;
            for (int w = 0; w < 4; w++) begin
                if (w == stall_before) begin
                    Sys_rdy = 1'b0;
                    repeat (3) begin
                        @(negedge Sys_clk);
                        chk("stall_en", {31'd0, bus.ICMC_en}, 32'd1);
                        chk("stall_addr", bus.ICMC_addr, base + 32'(4 * w));
                    end
                    Sys_rdy = 1'b1;
                end
                if (rand_gap) repeat ($urandom_range(0, 2)) @(negedge Sys_clk);
                chk("fill_en", {31'd0, bus.ICMC_en}, 32'd1);
                chk("fill_addr", bus.ICMC_addr, base + 32'(4 * w));
                if (w == 3 && !flushed) exp_q.push_back(mem_word({pc[31:2], 2'b00}));
                bus.MCIC_en   = 1'b1;
                bus.MCIC_data = mem_word(base + 32'(4 * w));
                @(negedge Sys_clk);
                bus.MCIC_en   = 1'b0;
                bus.MCIC_data = $urandom;
                if (w + 1 == flush_after && w < 3) begin
                    bus.RoBIC_flush = 1'b1;
                    flushed = 1'b1;
                    @(negedge Sys_clk);
                    bus.RoBIC_flush = 1'b0;
                end
            end
            chk("fill_done_en", {31'd0, bus.ICMC_en}, 32'd0);
            chk("resp_timing", {31'd0, bus.ICIF_en}, {31'd0, !flushed});
            m_valid[ix] = 1'b1;
            m_tag[ix]   = tg;
            @(negedge Sys_clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end
        Sys_rst         = 1'b0;
        Sys_rdy         = 1'b1;
        bus.IFIC_en     = 1'b0;
        bus.IFIC_pc     = '0;
        bus.RoBIC_flush = 1'b0;
        bus.MCIC_en     = 1'b0;
        bus.MCIC_data   = '0;
        repeat (2) @(negedge Sys_clk);
        chk("rst_icif_en", {31'd0, bus.ICIF_en}, 32'd0);
        chk("rst_icif_data", bus.ICIF_data, 32'd0);
        chk("rst_icmc_en", {31'd0, bus.ICMC_en}, 32'd0);
        chk("rst_icmc_addr", bus.ICMC_addr, 32'd0);
        Sys_rst = 1'b1;
        @(negedge Sys_clk);

        // Cold miss, hit after fill, conflict eviction
        fetch(32'h0000_0000, 0, -1, 1'b0);
        fetch(32'h0000_0008, 0, -1, 1'b0);
        fetch(32'h0000_0100, 0, -1, 1'b0);
        // Flush after the second beat: line fills, no response
        fetch(32'h0000_0000, 2, -1, 1'b0);
        fetch(32'h0000_0004, 0, -1, 1'b0);

        // Flush in IDLE blocks a same-cycle request
        bus.IFIC_pc     = 32'h0000_0004;
        bus.IFIC_en     = 1'b1;
        bus.RoBIC_flush = 1'b1;
        @(negedge Sys_clk);
        bus.IFIC_en     = 1'b0;
        bus.RoBIC_flush = 1'b0;
        chk("idle_flush_no_resp", {31'd0, bus.ICIF_en}, 32'd0);
        chk("idle_flush_no_mem", {31'd0, bus.ICMC_en}, 32'd0);
        @(negedge Sys_clk);

        // Sys_rdy stall in the middle of a fill
        fetch(32'h0000_0324, 0, 2, 1'b0);

        // Reset after one beat abandons the fill; stray MCIC_en ignored
        bus.IFIC_pc = 32'h0000_0200;
        bus.IFIC_en = 1'b1;
        @(negedge Sys_clk);
        bus.IFIC_en = 1'b0;
        chk("rstfill_en", {31'd0, bus.ICMC_en}, 32'd1);
        chk("rstfill_addr", bus.ICMC_addr, 32'h0000_0200);
        bus.MCIC_en   = 1'b1;
        bus.MCIC_data = mem_word(32'h0000_0200);
        @(negedge Sys_clk);
        bus.MCIC_en = 1'b0;
        Sys_rst     = 1'b0;
        @(negedge Sys_clk);
        chk("rstfill_mem_off", {31'd0, bus.ICMC_en}, 32'd0);
        chk("rstfill_addr_clr", bus.ICMC_addr, 32'd0);
        Sys_rst       = 1'b1;
        bus.MCIC_en   = 1'b1;
        bus.MCIC_data = 32'hDEAD_BEEF;
        @(negedge Sys_clk);
        bus.MCIC_en = 1'b0;
        chk("stray_mem_off", {31'd0, bus.ICMC_en}, 32'd0);
        chk("stray_no_resp", {31'd0, bus.ICIF_en}, 32'd0);
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        fetch(32'h0000_0000, 0, -1, 1'b0);

        // Randomized traffic over 4 tags so hits, misses and evictions mix
        for (int n = 0; n < 60; n++) begin
            logic [31:0] pc;
            int          fl;
            int          st;
            pc = (32'($urandom_range(0, 3)) << 8) | 32'($urandom_range(0, 255));
            fl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
            st = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            fetch(pc, fl, st, 1'b1);
        end

        repeat (3) @(negedge Sys_clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
Direct-mapped, read-only instruction cache between the instruction fetcher and the memory controller. It takes one fetch request (pc) at a time from the fetcher. A hit returns the 32-bit instruction word; a miss fills the whole line word-by-word from the memory controller, then returns the requested word. A misprediction flush from the RoB cancels any pending response to the fetcher.

Parameters:
ADDR_WIDTH, 32, byte address width
INDEX_BITS, 4, log2 of line count (16 lines)
OFFSET_BITS, 2, log2 of words per line (4 words = 16 B)

Ports:
Sys_clk  in  1  clock, all state updates on rising edge
Sys_rst  in  1  reset, synchronous, active-low (0 = reset)
Sys_rdy  in  1  global enable; 0 freezes all state
IFIC_en  in  1  fetch request level from fetcher
IFIC_pc  in  ADDR_WIDTH  fetch byte address
ICIF_en  out  1  one-cycle pulse: ICIF_data valid
ICIF_data  out  32  instruction word
RoBIC_flush  in  1  misprediction flush; drop any response not yet delivered
ICMC_en  out  1  word read request to memory controller
ICMC_addr  out  ADDR_WIDTH  word-aligned read address
MCIC_en  in  1  one-cycle pulse: MCIC_data valid for current ICMC_addr
MCIC_data  in  32  returned word

Behaviour:
- Address split: pc[1:0] ignored; offset = pc[OFFSET_BITS+1:2]; index = next INDEX_BITS bits; tag = remaining upper bits.
- Reset (Sys_rst=0 at an edge): all valid bits 0, state IDLE, ICIF_en=0, ICIF_data=0, ICMC_en=0, ICMC_addr=0. This takes priority over Sys_rdy. Reset during a fill abandons the fill; a late MCIC_en is ignored.
- Sys_rdy=0: no state, array or output register changes. Outputs hold.
- States: IDLE, FILL, RESP.
- IDLE:
  - A request is accepted when IFIC_en=1 and ICIF_en=0. No request is accepted in the cycle ICIF_en is high, because the fetcher's pc is still stale then.
  - On accept, latch pc.
  - Hit (valid[index] and tag match): next edge ICIF_en=1, ICIF_data = line[offset]. Hit latency is 1 cycle; peak throughput is 1 word per 2 cycles.
  - Miss: go to FILL, word counter k=0, ICMC_en=1, ICMC_addr = {tag,index,k,2'b00}.
- FILL:
  - ICMC_en stays high. On each MCIC_en, write MCIC_data into line word k.
  - If k < last: k++ and ICMC_addr advances by 4 on the same edge.
  - On the last word: ICMC_en=0, write tag and set valid, go to RESP.
  - MCIC_en while ICMC_en=0 is ignored.
- RESP (one cycle): ICIF_en=1, ICIF_data = the requested word (offset latched at accept); return to IDLE.
- ICIF_en is high for exactly one cycle per accepted, unflushed request.
- Flush (RoBIC_flush=1 at an edge):
  - In IDLE, a same-cycle request is not accepted and an ICIF_en about to rise is suppressed (ICIF_en<=0).
  - In FILL, the fill continues to completion and the line becomes valid, but RESP is skipped and the block returns to IDLE with no ICIF_en.
  - Flush while ICIF_en=1 forces ICIF_en<=0 on that edge; the pulse already visible that cycle stands.
- Replacement: a new line overwrites the line at its index unconditionally. Valid bits only clear on reset; there is no fence.i support.
- Back-to-back: a miss on the same index as a just-filled line evicts it. No hazard, since the array is written before RESP.

Decomposition:
- Shared package: ADDR_WIDTH, INDEX_BITS, OFFSET_BITS, the derived TAG_BITS and LINE_WORDS, and state encodings IC_IDLE/IC_FILL/IC_RESP.
- One sub-module, icache_line_store: valid, tag and data arrays. It has a combinational read port (index, offset -> hit, word), a per-word data write port, and a tag/valid write port with synchronous clear.
- FSM and memory handshake stay in icache_direct.

Test Plan:
- Cold miss pc=0x0: ICMC_addr 0x0,0x4,0x8,0xC each answered by MCIC_en with data 0x13,0x93,0x113,0x193 -> ICIF_en pulses once, 1 cycle after the last MCIC_en, with ICIF_data=0x13.
- Hit after fill, pc=0x8 -> ICIF_en high the cycle after accept, data=0x113, ICMC_en stays 0. IFIC_en held high during the ICIF_en cycle is not double-accepted.
- Conflict: pc=0x100 (index 0, new tag) -> 4-word refill at 0x100..0x10C, response word 0. A later pc=0x0 misses again.
- Flush mid-fill: RoBIC_flush pulse after the 2nd MCIC_en -> fill completes, no ICIF_en. A subsequent pc=0x4 hits with data=0x93.
- Reset mid-fill: Sys_rst=0 after 1 word -> ICMC_en=0 next edge. A stray MCIC_en is ignored. A later pc=0x0 misses.
- Sys_rdy=0 for 3 cycles during FILL with MCIC_en held 0 -> state, ICMC_addr and k unchanged; fill resumes when Sys_rdy=1.
